// File: rtl/y86_mem_arbiter.sv
// Arbitrates the single-port Y86 memory between fetch (read-only) and the memory stage (read/write),
// with bounds checking, a per-access timeout, starvation-limited data priority and a sticky halt.
module y86_mem_arbiter #(
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 64,
    parameter int MEM_WORDS       = 64,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ack_err,
    output logic              halt,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_D, RESP} state_t;

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LIMIT      = ADDR_W'(MEM_WORDS);
    localparam logic [SW-1:0]     STREAK_MAX = SW'(MAX_DATA_STREAK);
    localparam logic [TW-1:0]     TIMER_LAST = TW'(TIMEOUT - 1);

    state_t            state;
    logic [SW-1:0]     streak;
    logic [TW-1:0]     timer;
    logic              grant_d;
    logic              grant_f;
    logic [ADDR_W-1:0] g_addr;
    logic              g_oor;

    // Data has priority until it has won MAX_DATA_STREAK grants in a row over a waiting fetch.
    always_comb begin
        grant_d = d_req && (!f_req || (streak != STREAK_MAX));
        grant_f = f_req && !grant_d;
        g_addr  = grant_d ? d_addr : f_addr;
        g_oor   = (g_addr >= LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            streak    <= '0;
            timer     <= '0;
            f_ack     <= 1'b0;
            d_ack     <= 1'b0;
            f_rdata   <= '0;
            d_rdata   <= '0;
            ack_err   <= 1'b0;
            halt      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d || grant_f) begin
                        timer <= '0;
                        if (grant_d && f_req)
                            streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
                        else
                            streak <= '0;
                        if (g_oor) begin
                            // Out-of-range: respond with an error without touching memory.
                            state   <= RESP;
                            f_ack   <= grant_f;
                            d_ack   <= grant_d;
                            ack_err <= 1'b1;
                            halt    <= 1'b1;
                        end else begin
                            state     <= grant_d ? BUSY_D : BUSY_F;
                            mem_req   <= 1'b1;
                            mem_addr  <= g_addr;
                            mem_we    <= grant_d && d_we;
                            mem_wdata <= grant_d ? d_wdata : '0;
                        end
                    end
                end
                BUSY_F, BUSY_D: begin
                    if (mem_ready) begin
                        if (state == BUSY_F)
                            f_rdata <= mem_rdata;
                        else if (!mem_we)
                            d_rdata <= mem_rdata;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= RESP;
                        f_ack   <= (state == BUSY_F);
                        d_ack   <= (state == BUSY_D);
                        ack_err <= 1'b0;
                    end else if (timer == TIMER_LAST) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= RESP;
                        f_ack   <= (state == BUSY_F);
                        d_ack   <= (state == BUSY_D);
                        ack_err <= 1'b1;
                        halt    <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    f_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    ack_err <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Directed self-checking bench for y86_mem_arbiter with a small behavioural memory model.
module tb_y86_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_req = 1'b0;
    logic [63:0] f_addr = '0;
    logic        f_ack;
    logic [63:0] f_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [63:0] d_addr = '0;
    logic [63:0] d_wdata = '0;
    logic        d_ack;
    logic [63:0] d_rdata;
    logic        ack_err;
    logic        halt;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;
    logic        ready_en = 1'b1;

    int checks = 0;
    int errors = 0;

    // Unwritten words read back as 0x122F + addr, so word 5 reads 0x1234.
    logic [63:0] mem [0:63];
    logic        written [0:63];
    logic [5:0]  midx;

    assign midx      = mem_addr[5:0];
    assign mem_ready = ready_en;
    assign mem_rdata = written[midx] ? mem[midx] : (64'h122F + {58'h0, midx});

    always @(posedge clk) begin
        if (mem_req && mem_ready && mem_we) begin
            mem[midx]     <= mem_wdata;
            written[midx] <= 1'b1;
        end
    end

    always #5 clk = ~clk;

    y86_mem_arbiter #(
        .ADDR_W(64), .DATA_W(64), .MEM_WORDS(64), .MAX_DATA_STREAK(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .ack_err(ack_err), .halt(halt),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        f_req = 1'b0;
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drives one request at a negedge and waits (bounded) for its ack. cycles counts negedges
    // from the drive until the ack is seen; -1 means no ack arrived.
    task automatic run_txn(input bit data, input bit we, input logic [63:0] addr,
                           input logic [63:0] wdata, output int cycles, output int mrq,
                           output logic [63:0] m_addr, output logic m_we,
                           output logic [63:0] m_wdata, output logic fa, output logic da,
                           output logic err);
        bit seen = 0;
        cycles = -1; mrq = 0; m_addr = '0; m_we = 0; m_wdata = '0; fa = 0; da = 0; err = 0;
        @(negedge clk);
        if (data) begin
            d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        end else begin
            f_addr = addr; f_req = 1'b1;
        end
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_req) begin
                mrq++;
                if (!seen) begin
                    m_addr = mem_addr; m_we = mem_we; m_wdata = mem_wdata; seen = 1;
                end
            end
            if (f_ack || d_ack) begin
                cycles = c; fa = f_ack; da = d_ack; err = ack_err;
                break;
            end
        end
        f_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({f_ack, d_ack, ack_err, halt, mem_req, mem_we} !== 6'b0 ||
            f_rdata !== 64'h0 || d_rdata !== 64'h0 || mem_addr !== 64'h0 || mem_wdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: ctrl=%b f_rdata=%h d_rdata=%h expected all zero",
                     {f_ack, d_ack, ack_err, halt, mem_req, mem_we}, f_rdata, d_rdata);
        end
        do_reset();
    endtask

    task automatic test_fetch();
        int cyc, mrq; logic [63:0] ma, mw; logic we, fa, da, err;
        run_txn(0, 0, 64'd5, 64'h0, cyc, mrq, ma, we, mw, fa, da, err);
        // Ack at the second negedge after driving: the third cycle counting the drive cycle.
        checks++;
        if (cyc !== 2) begin errors++; $display("FAIL fetch_latency: got %0d expected 2", cyc); end
        checks++;
        if (mrq !== 1 || ma !== 64'd5 || we !== 1'b0) begin
            errors++; $display("FAIL fetch_mem: mrq=%0d addr=%0d we=%b expected 1 5 0", mrq, ma, we);
        end
        checks++;
        if (fa !== 1'b1 || da !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL fetch_ack: f=%b d=%b err=%b expected 1 0 0", fa, da, err);
        end
        checks++;
        if (f_rdata !== 64'h1234) begin
            errors++; $display("FAIL fetch_rdata: got %h expected 1234", f_rdata);
        end
    endtask

    task automatic test_data_rw();
        int cyc, mrq; logic [63:0] ma, mw; logic we, fa, da, err;
        run_txn(1, 1, 64'd10, 64'hDEAD, cyc, mrq, ma, we, mw, fa, da, err);
        checks++;
        if (we !== 1'b1 || mw !== 64'hDEAD || ma !== 64'd10) begin
            errors++; $display("FAIL write_mem: we=%b wdata=%h addr=%0d expected 1 dead 10", we, mw, ma);
        end
        checks++;
        if (da !== 1'b1 || fa !== 1'b0 || err !== 1'b0 || cyc !== 2) begin
            errors++; $display("FAIL write_ack: d=%b f=%b err=%b cyc=%0d expected 1 0 0 2", da, fa, err, cyc);
        end
        checks++;
        if (d_rdata !== 64'h0) begin
            errors++; $display("FAIL write_rdata_hold: got %h expected 0", d_rdata);
        end
        run_txn(1, 0, 64'd10, 64'h0, cyc, mrq, ma, we, mw, fa, da, err);
        checks++;
        if (da !== 1'b1 || we !== 1'b0 || d_rdata !== 64'hDEAD) begin
            errors++; $display("FAIL read_back: d=%b we=%b rdata=%h expected 1 0 dead", da, we, d_rdata);
        end
    endtask

    task automatic test_streak();
        logic [5:0] order = '0;
        int n = 0;
        @(negedge clk);
        f_addr = 64'd7; d_we = 1'b0; d_addr = 64'd20;
        f_req = 1'b1; d_req = 1'b1;
        for (int c = 0; c < 100 && n < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (d_ack) begin
                order[n] = 1'b1; n++;
                if (n == 6) d_req = 1'b0;
            end else if (f_ack) begin
                order[n] = 1'b0; n++;
                f_req = 1'b0;
                checks++;
                if (f_rdata !== 64'h1236) begin
                    errors++; $display("FAIL streak_f_rdata: got %h expected 1236", f_rdata);
                end
            end
        end
        f_req = 1'b0; d_req = 1'b0;
        // Bit i = 1 for a data grant: D,D,D,D,F,D.
        checks++;
        if (n !== 6 || order !== 6'b101111) begin
            errors++; $display("FAIL streak_order: n=%0d order=%b expected 6 101111", n, order);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_out_of_range();
        int cyc, mrq; logic [63:0] ma, mw; logic we, fa, da, err;
        run_txn(1, 0, 64'd64, 64'h0, cyc, mrq, ma, we, mw, fa, da, err);
        checks++;
        if (mrq !== 0 || da !== 1'b1 || err !== 1'b1 || cyc !== 1) begin
            errors++; $display("FAIL oor_data: mrq=%0d d=%b err=%b cyc=%0d expected 0 1 1 1", mrq, da, err, cyc);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (halt !== 1'b1) begin errors++; $display("FAIL oor_halt: got %b expected 1", halt); end
        run_txn(1, 0, 64'd63, 64'h0, cyc, mrq, ma, we, mw, fa, da, err);
        checks++;
        if (mrq !== 1 || da !== 1'b1 || err !== 1'b0 || d_rdata !== 64'h126E || halt !== 1'b1) begin
            errors++; $display("FAIL edge_63: mrq=%0d d=%b err=%b rdata=%h halt=%b expected 1 1 0 126e 1",
                               mrq, da, err, d_rdata, halt);
        end
        run_txn(0, 0, 64'h1_0000_0005, 64'h0, cyc, mrq, ma, we, mw, fa, da, err);
        checks++;
        if (mrq !== 0 || fa !== 1'b1 || err !== 1'b1) begin
            errors++; $display("FAIL oor_wide_fetch: mrq=%0d f=%b err=%b expected 0 1 1", mrq, fa, err);
        end
    endtask

    task automatic test_timeout();
        int cyc, mrq; logic [63:0] ma, mw; logic we, fa, da, err;
        do_reset();
        ready_en = 1'b0;
        run_txn(1, 0, 64'd2, 64'h0, cyc, mrq, ma, we, mw, fa, da, err);
        checks++;
        if (mrq !== 16 || cyc !== 17) begin
            errors++; $display("FAIL timeout_len: mrq=%0d cyc=%0d expected 16 17", mrq, cyc);
        end
        checks++;
        if (da !== 1'b1 || err !== 1'b1 || halt !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL timeout_err: d=%b err=%b halt=%b mem_req=%b expected 1 1 1 0",
                               da, err, halt, mem_req);
        end
    endtask

    task automatic test_reset_mid_op();
        int cyc, mrq; logic [63:0] ma, mw; logic we, fa, da, err;
        ready_en = 1'b0;
        @(negedge clk);
        d_we = 1'b0; d_addr = 64'd4; d_req = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || halt !== 1'b1) begin
            errors++; $display("FAIL midop_busy: mem_req=%b halt=%b expected 1 1", mem_req, halt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || d_ack !== 1'b0 || halt !== 1'b0) begin
            errors++; $display("FAIL midop_reset: mem_req=%b d_ack=%b halt=%b expected 0 0 0",
                               mem_req, d_ack, halt);
        end
        d_req = 1'b0;
        ready_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(0, 0, 64'd3, 64'h0, cyc, mrq, ma, we, mw, fa, da, err);
        checks++;
        if (cyc !== 2 || fa !== 1'b1 || err !== 1'b0 || f_rdata !== 64'h1232 || halt !== 1'b0) begin
            errors++; $display("FAIL midop_fresh_fetch: cyc=%0d f=%b err=%b rdata=%h halt=%b expected 2 1 0 1232 0",
                               cyc, fa, err, f_rdata, halt);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) written[i] = 1'b0;
        test_reset();
        test_fetch();
        test_data_rw();
        test_streak();
        test_out_of_range();
        test_timeout();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/y86_mem_arbiter.md
Name: y86_mem_arbiter

Overview:
Sequences and shares the single-port Y86 data/instruction memory between the fetch stage (read-only) and the memory stage (read/write). Performs bounds checking, per-transaction timeout and starvation-free priority arbitration. Returns per-requester acks with read data and an error flag. Raises a sticky halt on any error.

Parameters:
ADDR_W, 64, width of requester and memory addresses (word addresses)
DATA_W, 64, data word width
MEM_WORDS, 64, number of valid words; addr >= MEM_WORDS is out of range
MAX_DATA_STREAK, 4, max consecutive data grants while fetch is pending
TIMEOUT, 16, cycles to wait for mem_ready before error

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
f_req  in  1  fetch read request, held until f_ack
f_addr  in  ADDR_W  fetch word address
f_ack  out  1  one-cycle fetch completion pulse
f_rdata  out  DATA_W  fetch read data, valid with f_ack
d_req  in  1  memory-stage request, held until d_ack
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data word address (valE or valA selected upstream)
d_wdata  in  DATA_W  write data
d_ack  out  1  one-cycle data completion pulse
d_rdata  out  DATA_W  read data (valM), valid with d_ack
ack_err  out  1  error qualifier, valid with f_ack/d_ack
halt  out  1  sticky error flag, cleared only by reset
mem_req  out  1  memory access request, held until mem_ready
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid when mem_ready
mem_ready  in  1  memory completion, sampled only while mem_req=1

Behaviour:
- Reset (async, rst_n=0): state=IDLE; streak=0; timer=0. All outputs are 0, including mem_req, which drops immediately. A transaction in flight is abandoned and no ack is issued.
- States: IDLE, BUSY_F, BUSY_D, RESP.
- All outputs are registered. Requesters may change inputs only after seeing their ack.
- IDLE arbitration, evaluated each cycle:
  - Neither req: stay in IDLE.
  - Only one req: that requester wins.
  - Both reqs: data wins unless streak == MAX_DATA_STREAK, in which case fetch wins.
- Streak counter update at each grant:
  - Data grant with f_req=1: streak += 1, saturating at MAX_DATA_STREAK.
  - Fetch grant, or data grant with f_req=0: streak = 0.
- On a grant, bounds are checked first. If the winner's addr >= MEM_WORDS, go to RESP with ack_err=1; no memory access occurs and halt is set.
- Otherwise, go to BUSY_F or BUSY_D:
  - Drive mem_req=1 and mem_addr. For a data grant, also drive mem_we=d_we and mem_wdata=d_wdata. For a fetch grant, mem_we=0.
  - Clear the timer.
- BUSY_x on a clock edge with mem_ready=1:
  - Latch mem_rdata into f_rdata or d_rdata; reads only, a write leaves d_rdata unchanged.
  - mem_req=0; go to RESP with ack_err=0.
- BUSY_x without mem_ready: timer += 1. When timer reaches TIMEOUT-1 without mem_ready: mem_req=0, RESP with ack_err=1, halt=1.
- RESP lasts exactly one cycle:
  - The winner's ack=1; the other ack=0; rdata holds.
  - Next state is IDLE, with ack and ack_err returning to 0.
  - The requester sees the ack at the closing edge and drops req, so no double grant occurs.
- Latency: minimum 3 cycles from the req sample edge to the ack-high cycle with zero-wait memory (grant, access, RESP). Throughput: one transaction per 3 cycles.
- halt does not block arbitration. The enclosing processor stops on halt.
- Requests arriving during BUSY or RESP wait; there is no preemption.
- Address arithmetic is unsigned full ADDR_W; there is no truncation before the bounds check.

Test Plan:
1. Reset then a single fetch: f_req=1, f_addr=5, memory returns 0x1234 with zero wait -> mem_req high for 1 cycle with mem_addr=5, mem_we=0; f_ack=1 with f_rdata=0x1234, ack_err=0, exactly 3 cycles after the request edge.
2. Data write then read: d_we=1, d_addr=10, d_wdata=0xDEAD -> mem_we=1, mem_wdata=0xDEAD; d_ack=1. Then d_we=0, d_addr=10 -> d_rdata=0xDEAD.
3. Contention with MAX_DATA_STREAK=4: f_req held and d_req re-asserted after every ack -> grant order D,D,D,D,F,D,... The fetch ack occurs on the 5th transaction.
4. Out of range: d_addr=64 (MEM_WORDS=64) -> mem_req stays 0; d_ack=1 with ack_err=1; halt=1 and stays 1 until rst_n=0. d_addr=63 completes normally.
5. Timeout: mem_ready tied 0 -> mem_req high for TIMEOUT cycles then drops; ack_err=1 with the ack; halt=1.
6. Reset mid-operation: rst_n=0 during BUSY_D with mem_ready low -> mem_req, d_ack and halt are 0 immediately. After release, IDLE accepts a fresh f_req normally.
